atm_session_ctrl: RTL
=====================

# atm_session_ctrl

Parametrised ATM session controller: next-generation replacement for the single-account `ATM` FSM, serving `NUM_ACCOUNTS` accounts held in an internal register table. It authenticates a card/PIN pair, then executes balance, withdraw, deposit, transfer and PIN-change operations against that table. A cycle-accurate inactivity timeout and PIN-retry accounting are built in. It sits between the card/keypad front-end and the receipt and dispense logic.

## Interface
- `NUM_ACCOUNTS`, 4: table entries (≥2).
- `ACCT_W`, 17: account number width.
- `PIN_W`, 17: PIN width.
- `AMT_W`, 15: transaction amount width.
- `BAL_W`, 18: balance width (≥ `AMT_W`).
- `MAX_TRIES`, 3: bad PINs before lock (lockout build only).
- `TIMEOUT_CYC`, 64: idle cycles before forced eject.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: table write strobe; accepted only in IDLE.
- `cfg_idx` in clog2(NUM_ACCOUNTS): table index for `cfg_we`.
- `cfg_acct`/`cfg_pin`/`cfg_bal` in ACCT_W/PIN_W/BAL_W: entry contents; `cfg_we` also sets the entry valid bit.
- `Card_in` in 1: card present.
- `ur_account` in ACCT_W: card account number.
- `pin_valid` in 1: one-cycle strobe; `password` is sampled on this strobe.
- `password` in PIN_W: entered PIN.
- `op_valid` in 1: one-cycle strobe; `opcode` and the operands are sampled on this strobe.
- `opcode` in 3: 001 balance, 010 withdraw, 011 deposit, 100 transfer, 101 change PIN; others are invalid.
- `amount` in AMT_W: withdraw, deposit or transfer amount.
- `Pers_Account_No` in ACCT_W: transfer destination.
- `new_pin` in PIN_W: replacement PIN.
- `money_counting` in 1: deposit cash counted.
- `take_receipt` in 1: receipt requested.
- `another_transaction_bit` in 1: return to MENU when 1; eject when 0.
- `busy` out 1: not in IDLE.
- `Balance_Out` out BAL_W: registered balance; updated on a balance operation.
- `Balance_Shown`, `Withdrew_Successfully`, `Deposited_Successfully`, `Transfer_Successfully`, `Pin_Changed_Successfully`, `Receipt_Printed`, `Op_Error`, `Pin_Error`, `Timeout_Eject`, `ATM_Usage_Finished` out 1 each: one-cycle pulses.
- `Locked` out 1: level; the card's account is locked (lockout build only, otherwise 0).

## Operation
- **States:** IDLE, AUTH, MENU, EXEC, RECEIPT, ASK, EJECT.
- **IDLE:**
  - On `Card_in`=1, look up `ur_account` in the table.
  - If the account is found and valid, go to AUTH.
  - If not found, pulse `Op_Error` and go to EJECT.
- **AUTH:** on `pin_valid`, compare `password` with the stored PIN.
  - Match: go to MENU and clear the entry's try counter.
  - Mismatch: pulse `Pin_Error`. Further behaviour is set in Configuration.
- **MENU:** on `op_valid`, latch opcode and operands, then go to EXEC.
- **EXEC:** one cycle, except a deposit with `money_counting`=0, which holds in EXEC. The table update commits on the EXEC exit edge.
  - Balance: `Balance_Out` ← balance; pulse `Balance_Shown`.
  - Withdraw: succeeds if `amount` ≤ balance. Debit and pulse `Withdrew_Successfully`; otherwise pulse `Op_Error`.
  - Deposit: waits for `money_counting`=1. Credit if balance + amount < 2^BAL_W (checked at BAL_W+1 bits) and pulse `Deposited_Successfully`; otherwise pulse `Op_Error`.
  - Transfer: succeeds only if all of these hold:
    - the destination exists and is valid;
    - the destination differs from the own account;
    - `amount` ≤ balance;
    - the destination balance does not overflow.
    - On success, debit and credit in the same edge and pulse `Transfer_Successfully`; otherwise pulse `Op_Error`.
  - Change PIN: store `new_pin`; pulse `Pin_Changed_Successfully`.
  - Invalid opcode: pulse `Op_Error`; no table change.
- **Exit from EXEC:**
  - On success, go to RECEIPT.
  - On error, go to ASK.
- **RECEIPT:** if `take_receipt`=1, pulse `Receipt_Printed`. Go to ASK.
- **ASK:** on `op_valid`:
  - `another_transaction_bit`=1: go to MENU.
  - otherwise: go to EJECT.
- **EJECT:** pulse `ATM_Usage_Finished`; wait for `Card_in`=0, then go to IDLE.
- **Card removal:** `Card_in`=0 in any state other than IDLE or EJECT goes to IDLE next cycle. There is no commit unless the EXEC exit edge has already occurred.

## Timing
- **Reset values:**
  - state IDLE;
  - all pulse outputs 0;
  - `Balance_Out`=0, `busy`=0, `Locked`=0;
  - all table valid bits, try counters and lock bits cleared.
- Reset asserted mid-operation aborts the operation with no partial table write.
- **Latency, MENU `op_valid` to success pulse:** 2 cycles (MENU→EXEC, pulse on the EXEC exit edge).
- **Latency, to `Receipt_Printed`:** +1 cycle.
- All outputs are registered; there are no combinational paths from input to output.
- **Timeout counter:**
  - Clears on entry to each state and on each accepted strobe.
  - Increments every cycle in AUTH, MENU, EXEC-wait and ASK.
  - When it reaches `TIMEOUT_CYC`, pulse `Timeout_Eject` and go to EJECT.
- If a strobe and the timeout land in the same cycle, the strobe wins.
- `cfg_we` outside IDLE is ignored.
- On duplicate account numbers in the table, the lowest index wins.

## Configuration
- **`ATM_LOCKOUT_EN` defined:**
  - Each entry carries a try counter and a lock bit.
  - A mismatch increments the counter and stays in AUTH.
  - At `MAX_TRIES`, set the lock bit, assert `Locked`, and go to EJECT.
  - A locked account is refused at IDLE: `Op_Error` → EJECT, with `Locked`=1 until the card is removed.
- **Undefined:**
  - Any mismatch goes to EJECT.
  - There are no counters or lock bits, and `Locked` is tied to 0.

## Test plan
- **Withdraw:** load idx0 {C5AA, 1F5E, 0x100}; card, PIN 1F5E, withdraw 0x44 → `Withdrew_Successfully` 2 cycles after `op_valid`; a subsequent balance op gives `Balance_Out`=0xBC.
- **Transfer:** load idx1 {705C, 1234, 0}.
  - Transfer 200 from C5AA to 705C with balance 300 → `Transfer_Successfully`; balances 100 and 200.
  - Transfer C5AA to C5AA → `Op_Error`; no change.
- **Boundaries:**
  - Deposit 0x7FFF onto balance 0x3FFFF → `Op_Error`; balance unchanged.
  - Withdraw equal to balance → success; balance 0.
- **Lockout (`ATM_LOCKOUT_EN`):** three wrong PINs → three `Pin_Error` pulses, `Locked`=1, EJECT; reinsert C5AA → `Op_Error`. Non-lockout build: one wrong PIN → EJECT.
- **Timeout:** idle in MENU for 64 cycles → `Timeout_Eject` on cycle 64. Strobe coincident with cycle 64 → no eject.
- **Abort:**
  - Drop `Card_in` in a deposit EXEC-wait → IDLE; balance unchanged.
  - Assert `reset` mid-transfer → all outputs 0, table invalid.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN authentication and account operations against an internal table.
// Build option: define ATM_LOCKOUT_EN for per-account PIN-retry counting and lockout.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no card; table writable via cfg_we; card lookup on Card_in
// AUTH    | card accepted, waiting for pin_valid
// MENU    | authenticated, waiting for op_valid
// EXEC    | executing latched op; deposit holds here until money_counting
// RECEIPT | success path, optional receipt pulse
// ASK     | waiting for op_valid to pick another transaction or eject
// EJECT   | session over, waiting for card removal
module atm_session_ctrl #(
    parameter int NUM_ACCOUNTS = 4,
    parameter int ACCT_W       = 17,
    parameter int PIN_W        = 17,
    parameter int AMT_W        = 15,
    parameter int BAL_W        = 18,
    parameter int MAX_TRIES    = 3,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_ACCOUNTS)-1:0] cfg_idx,
    input  logic [ACCT_W-1:0]               cfg_acct,
    input  logic [PIN_W-1:0]                cfg_pin,
    input  logic [BAL_W-1:0]                cfg_bal,
    input  logic                            Card_in,
    input  logic [ACCT_W-1:0]               ur_account,
    input  logic                            pin_valid,
    input  logic [PIN_W-1:0]                password,
    input  logic                            op_valid,
    input  logic [2:0]                      opcode,
    input  logic [AMT_W-1:0]                amount,
    input  logic [ACCT_W-1:0]               Pers_Account_No,
    input  logic [PIN_W-1:0]                new_pin,
    input  logic                            money_counting,
    input  logic                            take_receipt,
    input  logic                            another_transaction_bit,
    output logic                            busy,
    output logic [BAL_W-1:0]                Balance_Out,
    output logic                            Balance_Shown,
    output logic                            Withdrew_Successfully,
    output logic                            Deposited_Successfully,
    output logic                            Transfer_Successfully,
    output logic                            Pin_Changed_Successfully,
    output logic                            Receipt_Printed,
    output logic                            Op_Error,
    output logic                            Pin_Error,
    output logic                            Timeout_Eject,
    output logic                            ATM_Usage_Finished,
    output logic                            Locked
);

    localparam int IDX_W = $clog2(NUM_ACCOUNTS);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] OP_BAL  = 3'b001;
    localparam logic [2:0] OP_WD   = 3'b010;
    localparam logic [2:0] OP_DEP  = 3'b011;
    localparam logic [2:0] OP_XFER = 3'b100;
    localparam logic [2:0] OP_PIN  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_AUTH, S_MENU, S_EXEC, S_RECEIPT, S_ASK, S_EJECT
    } state_t;

    state_t state;

    logic [ACCT_W-1:0]       tbl_acct [NUM_ACCOUNTS];
    logic [PIN_W-1:0]        tbl_pin  [NUM_ACCOUNTS];
    logic [BAL_W-1:0]        tbl_bal  [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] tbl_valid;

`ifdef ATM_LOCKOUT_EN
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    logic [TRY_W-1:0]        tbl_tries [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] tbl_lock;
    logic [TRY_W-1:0]        tries_next;
`else
    // Retry limit has no meaning without lockout.
    logic unused_max_tries;
    assign unused_max_tries = (MAX_TRIES > 0);
    assign Locked = 1'b0;
`endif

    logic [IDX_W-1:0]  cur_idx;
    logic [2:0]        op_code;
    logic [AMT_W-1:0]  op_amt;
    logic [ACCT_W-1:0] op_dst;
    logic [PIN_W-1:0]  op_pin;
    logic [TMR_W-1:0]  tmr;

    logic             card_hit, dst_hit;
    logic [IDX_W-1:0] card_idx, dst_idx;

    // Descending scan so the lowest matching index wins on duplicates.
    always_comb begin
        card_hit = 1'b0;
        card_idx = '0;
        dst_hit  = 1'b0;
        dst_idx  = '0;
        for (int i = NUM_ACCOUNTS - 1; i >= 0; i--) begin
            if (tbl_valid[i] && tbl_acct[i] == ur_account) begin
                card_hit = 1'b1;
                card_idx = IDX_W'(i);
            end
            if (tbl_valid[i] && tbl_acct[i] == op_dst) begin
                dst_hit = 1'b1;
                dst_idx = IDX_W'(i);
            end
        end
    end

    logic [BAL_W-1:0] cur_bal, dst_bal;
    logic [BAL_W:0]   amt_ext, dep_sum, xfer_sum;
    logic             wd_ok, dep_ok, xfer_ok;

    assign cur_bal  = tbl_bal[cur_idx];
    assign dst_bal  = tbl_bal[dst_idx];
    assign amt_ext  = (BAL_W + 1)'(op_amt);
    assign dep_sum  = {1'b0, cur_bal} + amt_ext;
    assign xfer_sum = {1'b0, dst_bal} + amt_ext;
    assign wd_ok    = amt_ext <= {1'b0, cur_bal};
    assign dep_ok   = ~dep_sum[BAL_W];
    assign xfer_ok  = dst_hit && (op_dst != tbl_acct[cur_idx]) && wd_ok && ~xfer_sum[BAL_W];

`ifdef ATM_LOCKOUT_EN
    assign tries_next = tbl_tries[cur_idx] + TRY_W'(1);
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                    <= S_IDLE;
            tmr                      <= TMR_LOAD;
            cur_idx                  <= '0;
            op_code                  <= '0;
            op_amt                   <= '0;
            op_dst                   <= '0;
            op_pin                   <= '0;
            Balance_Out              <= '0;
            Balance_Shown            <= 1'b0;
            Withdrew_Successfully    <= 1'b0;
            Deposited_Successfully   <= 1'b0;
            Transfer_Successfully    <= 1'b0;
            Pin_Changed_Successfully <= 1'b0;
            Receipt_Printed          <= 1'b0;
            Op_Error                 <= 1'b0;
            Pin_Error                <= 1'b0;
            Timeout_Eject            <= 1'b0;
            ATM_Usage_Finished       <= 1'b0;
            tbl_valid                <= '0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                tbl_acct[i] <= '0;
                tbl_pin[i]  <= '0;
                tbl_bal[i]  <= '0;
`ifdef ATM_LOCKOUT_EN
                tbl_tries[i] <= '0;
`endif
            end
`ifdef ATM_LOCKOUT_EN
            tbl_lock <= '0;
            Locked   <= 1'b0;
`endif
        end else begin
            Balance_Shown            <= 1'b0;
            Withdrew_Successfully    <= 1'b0;
            Deposited_Successfully   <= 1'b0;
            Transfer_Successfully    <= 1'b0;
            Pin_Changed_Successfully <= 1'b0;
            Receipt_Printed          <= 1'b0;
            Op_Error                 <= 1'b0;
            Pin_Error                <= 1'b0;
            Timeout_Eject            <= 1'b0;
            ATM_Usage_Finished       <= 1'b0;
            // Reload by default; waiting states override with a decrement.
            tmr                      <= TMR_LOAD;

            if (state != S_IDLE && state != S_EJECT && !Card_in) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cfg_we && int'(cfg_idx) < NUM_ACCOUNTS) begin
                            tbl_acct[cfg_idx]  <= cfg_acct;
                            tbl_pin[cfg_idx]   <= cfg_pin;
                            tbl_bal[cfg_idx]   <= cfg_bal;
                            tbl_valid[cfg_idx] <= 1'b1;
`ifdef ATM_LOCKOUT_EN
                            tbl_tries[cfg_idx] <= '0;
                            tbl_lock[cfg_idx]  <= 1'b0;
`endif
                        end
                        if (Card_in) begin
`ifdef ATM_LOCKOUT_EN
                            if (card_hit && !tbl_lock[card_idx]) begin
`else
                            if (card_hit) begin
`endif
                                cur_idx <= card_idx;
                                state   <= S_AUTH;
                            end else begin
                                Op_Error           <= 1'b1;
                                ATM_Usage_Finished <= 1'b1;
                                state              <= S_EJECT;
`ifdef ATM_LOCKOUT_EN
                                Locked             <= card_hit;
`endif
                            end
                        end
                    end
                    S_AUTH: begin
                        if (pin_valid) begin
                            if (password == tbl_pin[cur_idx]) begin
                                state <= S_MENU;
`ifdef ATM_LOCKOUT_EN
                                tbl_tries[cur_idx] <= '0;
`endif
                            end else begin
                                Pin_Error <= 1'b1;
`ifdef ATM_LOCKOUT_EN
                                tbl_tries[cur_idx] <= tries_next;
                                if (tries_next >= TRY_W'(MAX_TRIES)) begin
                                    tbl_lock[cur_idx]  <= 1'b1;
                                    Locked             <= 1'b1;
                                    ATM_Usage_Finished <= 1'b1;
                                    state              <= S_EJECT;
                                end
`else
                                ATM_Usage_Finished <= 1'b1;
                                state              <= S_EJECT;
`endif
                            end
                        end else if (tmr == '0) begin
                            Timeout_Eject      <= 1'b1;
                            ATM_Usage_Finished <= 1'b1;
                            state              <= S_EJECT;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                    S_MENU: begin
                        if (op_valid) begin
                            op_code <= opcode;
                            op_amt  <= amount;
                            op_dst  <= Pers_Account_No;
                            op_pin  <= new_pin;
                            state   <= S_EXEC;
                        end else if (tmr == '0) begin
                            Timeout_Eject      <= 1'b1;
                            ATM_Usage_Finished <= 1'b1;
                            state              <= S_EJECT;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                    S_EXEC: begin
                        case (op_code)
                            OP_BAL: begin
                                Balance_Out   <= cur_bal;
                                Balance_Shown <= 1'b1;
                                state         <= S_RECEIPT;
                            end
                            OP_WD: begin
                                if (wd_ok) begin
                                    tbl_bal[cur_idx]      <= cur_bal - amt_ext[BAL_W-1:0];
                                    Withdrew_Successfully <= 1'b1;
                                    state                 <= S_RECEIPT;
                                end else begin
                                    Op_Error <= 1'b1;
                                    state    <= S_ASK;
                                end
                            end
                            OP_DEP: begin
                                if (!money_counting) begin
                                    if (tmr == '0) begin
                                        Timeout_Eject      <= 1'b1;
                                        ATM_Usage_Finished <= 1'b1;
                                        state              <= S_EJECT;
                                    end else begin
                                        tmr <= tmr - TMR_W'(1);
                                    end
                                end else if (dep_ok) begin
                                    tbl_bal[cur_idx]       <= dep_sum[BAL_W-1:0];
                                    Deposited_Successfully <= 1'b1;
                                    state                  <= S_RECEIPT;
                                end else begin
                                    Op_Error <= 1'b1;
                                    state    <= S_ASK;
                                end
                            end
                            OP_XFER: begin
                                if (xfer_ok) begin
                                    tbl_bal[cur_idx]      <= cur_bal - amt_ext[BAL_W-1:0];
                                    tbl_bal[dst_idx]      <= xfer_sum[BAL_W-1:0];
                                    Transfer_Successfully <= 1'b1;
                                    state                 <= S_RECEIPT;
                                end else begin
                                    Op_Error <= 1'b1;
                                    state    <= S_ASK;
                                end
                            end
                            OP_PIN: begin
                                tbl_pin[cur_idx]         <= op_pin;
                                Pin_Changed_Successfully <= 1'b1;
                                state                    <= S_RECEIPT;
                            end
                            default: begin
                                Op_Error <= 1'b1;
                                state    <= S_ASK;
                            end
                        endcase
                    end
                    S_RECEIPT: begin
                        Receipt_Printed <= take_receipt;
                        state           <= S_ASK;
                    end
                    S_ASK: begin
                        if (op_valid) begin
                            if (another_transaction_bit) begin
                                state <= S_MENU;
                            end else begin
                                ATM_Usage_Finished <= 1'b1;
                                state              <= S_EJECT;
                            end
                        end else if (tmr == '0) begin
                            Timeout_Eject      <= 1'b1;
                            ATM_Usage_Finished <= 1'b1;
                            state              <= S_EJECT;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                    S_EJECT: begin
                        if (!Card_in) begin
                            state <= S_IDLE;
`ifdef ATM_LOCKOUT_EN
                            Locked <= 1'b0;
`endif
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
